// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side view of the hazard/stall controller: ID/EX decode inputs in,
// PC/IF-ID enables and ID/EX bubble/flush controls out.
interface hazard_stall_ctrl_if;
  logic [5:0]  op_id;
  logic [5:0]  func_id;
  logic [4:0]  Rs_id;
  logic [4:0]  Rt_id;
  logic [5:0]  op_ex;
  logic [5:0]  func_ex;
  logic [4:0]  Rt_ex;
  logic        MemRead_ex;
  logic        loaduse_ex;
  logic        xiaoc_ex;
  logic        branch_taken;
  logic        pc_write;
  logic        ifid_write;
  logic        loaduse;
  logic        xiaoc;
  logic        mdu_busy;
  logic [15:0] stall_cycles;
  logic        mdu_state;

  // Level-based control, no handshake: the controller drives its outputs
  // combinationally every cycle and the pipeline samples them on the
  // falling edge together with its own pipeline registers.
  modport master (
    output op_id, func_id, Rs_id, Rt_id, op_ex, func_ex, Rt_ex,
           MemRead_ex, loaduse_ex, xiaoc_ex, branch_taken,
    input  pc_write, ifid_write, loaduse, xiaoc, mdu_busy, stall_cycles,
           mdu_state
  );
  modport slave (
    input  op_id, func_id, Rs_id, Rt_id, op_ex, func_ex, Rt_ex,
           MemRead_ex, loaduse_ex, xiaoc_ex, branch_taken,
    output pc_write, ifid_write, loaduse, xiaoc, mdu_busy, stall_cycles,
           mdu_state
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use and HI/LO hazard detection with taken-branch flush for the
// five-stage MIPS pipeline, plus a saturating stall-cycle debug counter.
module hazard_stall_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input logic            clk,
  input logic            rst_n,
  hazard_stall_ctrl_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_e;

  mdu_state_e  state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [15:0] stall_cnt;

  logic ex_valid;
  logic uses_rt;
  logic lu_haz;
  logic mdu_ex;
  logic hilo_id;
  logic mdu_haz;
  logic stall;

  assign ex_valid = !bus.loaduse_ex && !bus.xiaoc_ex;
  assign uses_rt  = (bus.op_id == 6'b000000) || (bus.op_id == 6'b000100) ||
                    (bus.op_id == 6'b000101) || (bus.op_id == 6'b101011);
  assign lu_haz   = bus.MemRead_ex && (bus.Rt_ex != 5'd0) &&
                    ((bus.Rt_ex == bus.Rs_id) || (uses_rt && (bus.Rt_ex == bus.Rt_id)));
  // func 0110xx covers mult, multu, div, divu
  assign mdu_ex   = ex_valid && (bus.op_ex == 6'd0) && (bus.func_ex[5:2] == 4'b0110);
  assign hilo_id  = (bus.op_id == 6'd0) &&
                    ((bus.func_id[5:2] == 4'b0100) || (bus.func_id[5:2] == 4'b0110));
  assign mdu_haz  = hilo_id && (bus.mdu_busy || mdu_ex);

  // A taken branch kills the ID instruction, so it never needs to stall.
  assign stall          = !bus.branch_taken && (lu_haz || mdu_haz);
  assign bus.xiaoc      = bus.branch_taken;
  assign bus.loaduse    = stall;
  assign bus.pc_write   = !stall;
  assign bus.ifid_write = !stall;
  assign bus.mdu_busy   = (cnt != 4'd0);
  assign bus.stall_cycles = stall_cnt;
  assign bus.mdu_state  = state;

  // A new mult/div in EX reloads the countdown even if one is running.
  always_comb begin
    cnt_next = cnt;
    if (mdu_ex)
      cnt_next = bus.func_ex[1] ? 4'(DIV_LAT) : 4'(MULT_LAT);
    else if (cnt != 4'd0)
      cnt_next = cnt - 4'd1;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      stall_cnt <= 16'd0;
    end else begin
      cnt   <= cnt_next;
      state <= (cnt_next != 4'd0) ? BUSY : IDLE;
      if (stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
